// File: rtl/ipsmacge_delay_line_if.sv
// ipsmacge delay line handshake bundle.
// Carries stream data, delay control and status between the core and its users.
interface ipsmacge_delay_line_if #(
  parameter int W  = 8,
  parameter int DW = 5
);
  logic          ce;
  logic          flush;
  logic [DW-1:0] cfg_dly;
  logic          ivld;
  logic [W-1:0]  idat;
  logic          ovld;
  logic [W-1:0]  odat;
  logic          rdy;
  logic          cfg_err;

  modport master (
    output ce, flush, cfg_dly, ivld, idat,
    input  ovld, odat, rdy, cfg_err
  );

  modport slave (
    input  ce, flush, cfg_dly, ivld, idat,
    output ovld, odat, rdy, cfg_err
  );
endinterface

// File: rtl/ipsmacge_delay_line.sv
// ipsmacge runtime-programmable delay line.
// 0..MAXD clock-enabled stages with on-the-fly delay change and settle gating.
module ipsmacge_delay_line #(
  parameter int W       = 8,
  parameter int MAXD    = 16,
  parameter int DW      = 5,
  parameter int RST_DLY = 3
) (
  input  logic clk,
  input  logic rst_,
  ipsmacge_delay_line_if.slave bus
);

  typedef enum logic {RUN, SETTLE} state_t;

  logic [MAXD:1] s_vld;
  logic [W-1:0]  s_dat [1:MAXD];
  logic [DW-1:0] cur_dly;
  logic [DW-1:0] cnt;
  state_t        state;
  logic          rdy_q;
  logic          err_q;
  logic          cfg_ok;
  logic          chg;
  logic          sel_vld;
  logic [W-1:0]  sel_dat;

  assign cfg_ok = bus.cfg_dly <= DW'(MAXD);
  assign chg    = cfg_ok && (bus.cfg_dly != cur_dly);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      s_vld <= '0;
      for (int i = 1; i <= MAXD; i++) s_dat[i] <= '0;
    end else if (bus.flush) begin
      s_vld <= '0;
      for (int i = 1; i <= MAXD; i++) s_dat[i] <= '0;
    end else if (bus.ce) begin
      for (int i = MAXD; i >= 2; i--) begin
        s_vld[i] <= s_vld[i-1];
        s_dat[i] <= s_dat[i-1];
      end
      s_vld[1] <= bus.ivld;
      s_dat[1] <= bus.ivld ? bus.idat : '0;
    end
  end

  // A change restarts the settle count so stale words never reach odat.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= RUN;
      cur_dly <= DW'(RST_DLY);
      cnt     <= '0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      err_q <= !cfg_ok;
      if (chg) begin
        cur_dly <= bus.cfg_dly;
        if (bus.flush || bus.cfg_dly == '0) begin
          state <= RUN;
          rdy_q <= 1'b1;
          cnt   <= '0;
        end else begin
          state <= SETTLE;
          rdy_q <= 1'b0;
          cnt   <= bus.cfg_dly;
        end
      end else if (bus.flush) begin
        state <= RUN;
        rdy_q <= 1'b1;
        cnt   <= '0;
      end else if (state == SETTLE && bus.ce) begin
        cnt <= cnt - 1'b1;
        if (cnt == DW'(1)) begin
          state <= RUN;
          rdy_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    if (cur_dly == '0) begin
      sel_vld = bus.ivld & ~bus.flush;
      sel_dat = sel_vld ? bus.idat : '0;
    end else begin
      for (int i = 1; i <= MAXD; i++) begin
        if (cur_dly == DW'(i)) begin
          sel_vld = s_vld[i];
          sel_dat = s_dat[i];
        end
      end
    end
  end

  assign bus.ovld    = (state == RUN) & sel_vld;
  assign bus.odat    = (state == RUN) ? sel_dat : '0;
  assign bus.rdy     = rdy_q;
  assign bus.cfg_err = err_q;

endmodule

// File: tb/tb_ipsmacge_delay_line.sv
// Scoreboard bench for ipsmacge_delay_line.
// Reference keeps a history queue of accepted words and picks by delay.
module tb_ipsmacge_delay_line;
  localparam int W       = 8;
  localparam int MAXD    = 16;
  localparam int DW      = 5;
  localparam int RST_DLY = 3;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  ipsmacge_delay_line_if #(.W(W), .DW(DW)) bus ();

  ipsmacge_delay_line #(
    .W(W), .MAXD(MAXD), .DW(DW), .RST_DLY(RST_DLY)
  ) dut (
    .clk(clk),
    .rst_(rst_),
    .bus(bus)
  );

  typedef struct packed {
    logic         ovld;
    logic [W-1:0] odat;
    logic         rdy;
    logic         cfg_err;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int    errors = 0;
  int    checks = 0;
  string tag = "reset";

  logic [W:0] hist[$];
  int         cur;
  bit         settling;
  int         remain;
  bit         cerr;
  int         cnt_w = 1;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < MAXD; i++) hist.push_back('0);
    cur      = RST_DLY;
    settling = 0;
    remain   = 0;
    cerr     = 0;
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.rdy     = !settling;
    e.cfg_err = cerr;
    e.ovld    = 1'b0;
    e.odat    = '0;
    if (!settling) begin
      if (cur == 0) begin
        e.ovld = bus.ivld & ~bus.flush;
        e.odat = e.ovld ? bus.idat : '0;
      end else begin
        {e.ovld, e.odat} = hist[cur-1];
      end
    end
    return e;
  endfunction

  task automatic model_edge(input bit c, input bit f, input int cfg,
                            input bit v, input logic [W-1:0] d);
    cerr = cfg > MAXD;
    if (cfg <= MAXD && cfg != cur) begin
      cur = cfg;
      if (f || cfg == 0) settling = 0;
      else begin
        settling = 1;
        remain   = cfg;
      end
    end else if (f) begin
      settling = 0;
    end else if (settling && c) begin
      remain--;
      if (remain == 0) settling = 0;
    end
    if (f) begin
      foreach (hist[i]) hist[i] = '0;
    end else if (c) begin
      hist.push_front({v, v ? d : {W{1'b0}}});
      void'(hist.pop_back());
    end
  endtask

  task automatic push_exp();
    q.push_back(expect_now());
    tq.push_back(tag);
  endtask

  task automatic step(input bit c, input bit f, input int cfg,
                      input bit v, input logic [W-1:0] d);
    bus.ce      = c;
    bus.flush   = f;
    bus.cfg_dly = DW'(cfg);
    bus.ivld    = v;
    bus.idat    = d;
    push_exp();
    @(posedge clk);
    model_edge(c, f, cfg, v, d);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string t;
      e = q.pop_front();
      t = tq.pop_front();
      g = '{bus.ovld, bus.odat, bus.rdy, bus.cfg_err};
      checks++;
      if (g !== e)
        $display("FAIL %s t=%0t got vld=%b dat=%h rdy=%b err=%b want vld=%b dat=%h rdy=%b err=%b",
                 t, $time, g.ovld, g.odat, g.rdy, g.cfg_err,
                 e.ovld, e.odat, e.rdy, e.cfg_err);
      if (g !== e) errors++;
    end
  end

  initial begin
    bus.ce = 0; bus.flush = 0; bus.cfg_dly = DW'(RST_DLY);
    bus.ivld = 0; bus.idat = '0;
    model_reset();
    #2 push_exp();
    #10 rst_ = 1'b1;
    @(posedge clk);
    model_edge(0, 0, RST_DLY, 0, '0);
    #1;

    tag = "stream_d3";
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 3, 1, W'(cnt_w)); cnt_w++;
    end

    tag = "change_3to7";
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 7, 1, W'(cnt_w)); cnt_w++;
    end

    tag = "bypass_d0";
    for (int i = 0; i < 16; i++) begin
      bit v;
      v = (i % 2 == 0);
      step(1, i == 6, 0, v, (i < 8) ? 8'hA5 : W'($urandom));
    end

    tag = "stall_d4";
    for (int i = 0; i < 30; i++) begin
      step(i % 3 == 0, 0, 4, 1, W'(cnt_w)); cnt_w++;
    end

    tag = "illegal_cfg";
    for (int i = 0; i < 8; i++) begin
      step(1, 0, MAXD + 1, 1, W'(cnt_w)); cnt_w++;
    end

    tag = "flush_settle";
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 9, 1, W'(cnt_w)); cnt_w++;
    end
    step(1, 1, 9, 1, 8'h5A);
    for (int i = 0; i < 4; i++) step(1, 0, 9, 0, '0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 9, 1, W'(cnt_w)); cnt_w++;
    end

    tag = "random";
    begin
      int cfg;
      cfg = 5;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(24) == 0) cfg = $urandom_range(MAXD + 2);
        step($urandom_range(3) != 0, $urandom_range(29) == 0, cfg,
             $urandom_range(1) == 1, W'($urandom));
      end
    end

    tag = "reset_in_settle";
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 10, 1, W'(cnt_w)); cnt_w++;
    end
    bus.ce = 0; bus.flush = 0; bus.cfg_dly = DW'(RST_DLY);
    bus.ivld = 0; bus.idat = '0;
    rst_ = 1'b0;
    model_reset();
    #1 push_exp();
    @(negedge clk);
    #2 rst_ = 1'b1;
    @(posedge clk);
    model_edge(0, 0, RST_DLY, 0, '0);
    #1;

    tag = "post_reset_d3";
    for (int i = 0; i < 12; i++) begin
      step(1, 0, RST_DLY, 1, W'(cnt_w)); cnt_w++;
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      $display("FAIL drain got %0d pending want 0", q.size());
      errors++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
